// File: rtl/reg_file_scoreboard_pkg.sv
// Shared constants and types for the integer register file and its
// pending-write scoreboard.
package reg_file_scoreboard_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;

  localparam int SB_CNT_W = 2;
  typedef logic [SB_CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/reg_file_scoreboard_scoreboard.sv
// Per-register in-flight write counters, busy vector, decode stall and the
// sticky overflow/underflow error flag.
module reg_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = SB_CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_issue_we,
  input  logic                  i_flush,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_rs1_used,
  input  logic                  i_rs2_used,
  output logic                  o_stall,
  output logic                  o_sb_err
);

  localparam int NREGS = 2**REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] ovf;
  logic [NREGS-1:0] unf;
  logic             err_q;
  logic             err_d;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == REG_ZERO) begin : g_zero
        // x0 has no counter: it is never busy and never faults.
        assign busy[gi] = 1'b0;
        assign ovf[gi]  = 1'b0;
        assign unf[gi]  = 1'b0;
      end else begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             inc;
        logic             dec;
        logic             ovf_d;
        logic             unf_d;

        assign inc = i_issue_valid & i_issue_we & (i_issue_rd == REG_ADDR_W'(gi));
        assign dec = i_wb_we & (i_wb_addr == REG_ADDR_W'(gi));

        always_comb begin
          cnt_d = cnt_q;
          ovf_d = 1'b0;
          unf_d = 1'b0;
          if (i_flush) begin
            cnt_d = '0;
          end else begin
            case ({inc, dec})
              2'b10: begin
                if (cnt_q == CNT_TOP) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + CNT_ONE;
              end
              2'b01: begin
                if (cnt_q == '0) unf_d = 1'b1;
                else             cnt_d = cnt_q - CNT_ONE;
              end
              default: cnt_d = cnt_q;
            endcase
          end
        end

        always_ff @(posedge i_clk) begin
          if (i_rst) cnt_q <= '0;
          else       cnt_q <= cnt_d;
        end

        // The last outstanding write landing this cycle is covered by bypass.
        assign busy[gi] = (cnt_q > CNT_ONE) | ((cnt_q == CNT_ONE) & ~dec);
        assign ovf[gi]  = ovf_d;
        assign unf[gi]  = unf_d;
      end
    end
  endgenerate

  assign err_d = err_q | (|ovf) | (|unf);

  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign o_sb_err = err_q;
  assign o_stall  = (i_rs1_used & busy[i_rs1_addr]) | (i_rs2_used & busy[i_rs2_addr]);

endmodule

// File: rtl/reg_file_scoreboard.sv
// Integer register file with same-cycle write-back bypass on both decode read
// ports and the a0 LSB, plus the pending-write scoreboard.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_rs1_used,
  input  logic                  i_rs2_used,
  output logic [DATA_WIDTH-1:0] o_rs1_data,
  output logic [DATA_WIDTH-1:0] o_rs2_data,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_issue_we,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_a0_lsb,
  output logic                  o_sb_err
);

  localparam int NREGS = 2**REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] ADDR_ZERO = REG_ADDR_W'(REG_ZERO);
  localparam logic [REG_ADDR_W-1:0] ADDR_A0   = REG_ADDR_W'(REG_A0);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];
  logic                  wb_commit;
  logic [DATA_WIDTH-1:0] a0_data;

  assign wb_commit = i_wb_we & (i_wb_addr != ADDR_ZERO);

  always_comb begin
    regs_d = regs_q;
    if (wb_commit) regs_d[i_wb_addr] = i_wb_data;
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (i_rst) regs_q[i] <= '0;
      else       regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    if (i_rs1_addr == ADDR_ZERO)                    o_rs1_data = '0;
    else if (i_wb_we && (i_wb_addr == i_rs1_addr))  o_rs1_data = i_wb_data;
    else                                            o_rs1_data = regs_q[i_rs1_addr];
  end

  always_comb begin
    if (i_rs2_addr == ADDR_ZERO)                    o_rs2_data = '0;
    else if (i_wb_we && (i_wb_addr == i_rs2_addr))  o_rs2_data = i_wb_data;
    else                                            o_rs2_data = regs_q[i_rs2_addr];
  end

  always_comb begin
    if (i_wb_we && (i_wb_addr == ADDR_A0)) a0_data = i_wb_data;
    else                                   a0_data = regs_q[ADDR_A0];
  end

  assign o_a0_lsb = a0_data[0];

  reg_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .CNT_W      (CNT_W)
  ) u_sb (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wb_we       (i_wb_we),
    .i_wb_addr     (i_wb_addr),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_issue_we    (i_issue_we),
    .i_flush       (i_flush),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .i_rs1_used    (i_rs1_used),
    .i_rs2_used    (i_rs2_used),
    .o_stall       (o_stall),
    .o_sb_err      (o_sb_err)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench: stimulus pushes expected outputs into a queue, a monitor
// compares them against the DUT on the falling edge of the same cycle.
module tb_reg_file_scoreboard;

  localparam int DW = 64;
  localparam int AW = 5;

  localparam int SEL_RS1   = 0;
  localparam int SEL_RS2   = 1;
  localparam int SEL_STALL = 2;
  localparam int SEL_A0    = 3;
  localparam int SEL_ERR   = 4;

  localparam time TIMEOUT = 100000;

  typedef struct {
    string         name;
    int            sel;
    logic [DW-1:0] exp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic          rs1_used, rs2_used;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_we;
  logic          flush;
  logic          stall;
  logic          a0_lsb;
  logic          sb_err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_file_scoreboard #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .CNT_W(2)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wb_we       (wb_we),
    .i_wb_addr     (wb_addr),
    .i_wb_data     (wb_data),
    .i_rs1_addr    (rs1_addr),
    .i_rs2_addr    (rs2_addr),
    .i_rs1_used    (rs1_used),
    .i_rs2_used    (rs2_used),
    .o_rs1_data    (rs1_data),
    .o_rs2_data    (rs2_data),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .i_issue_we    (issue_we),
    .i_flush       (flush),
    .o_stall       (stall),
    .o_a0_lsb      (a0_lsb),
    .o_sb_err      (sb_err)
  );

  function automatic void exp_push(input string n, input int sel, input logic [DW-1:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.exp  = v;
    exp_q.push_back(e);
  endfunction

  task automatic check_now(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", n, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h (t=%0t)", n, act, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t          e;
    logic [DW-1:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        SEL_RS1:   act = rs1_data;
        SEL_RS2:   act = rs2_data;
        SEL_STALL: act = {{(DW-1){1'b0}}, stall};
        SEL_A0:    act = {{(DW-1){1'b0}}, a0_lsb};
        default:   act = {{(DW-1){1'b0}}, sb_err};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", e.name, act, e.exp, $time);
      end else begin
        $display("ok   %s: 0x%0h (t=%0t)", e.name, act, $time);
      end
    end
  end

  initial begin
    #TIMEOUT;
    errors++;
    $display("FAIL timeout: simulation did not finish within %0t (t=%0t)", TIMEOUT, $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_we   = we;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] rd);
    issue_valid = v;
    issue_rd    = rd;
    issue_we    = v;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    wb(1'b0, '0, '0);
    issue(1'b0, '0);
    rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    step(); step();
    rst = 1'b0;

    // Post-reset: every register reads zero, nothing busy, no error.
    check_now("reset_err", {{(DW-1){1'b0}}, sb_err}, 0);
    check_now("reset_stall", {{(DW-1){1'b0}}, stall}, 0);
    for (int r = 1; r < 32; r++) begin
      rs1_addr = AW'(r); rs2_addr = AW'(r); rs1_used = 1'b1; rs2_used = 1'b1;
      exp_push($sformatf("reset_rs1_x%0d", r), SEL_RS1, 0);
      exp_push($sformatf("reset_rs2_x%0d", r), SEL_RS2, 0);
      exp_push($sformatf("reset_stall_x%0d", r), SEL_STALL, 0);
      step();
    end
    rs1_used = 1'b0; rs2_used = 1'b0;

    // x0 write is discarded and never faults.
    wb(1'b1, 5'd0, 64'hDEAD); rs1_addr = 5'd0;
    exp_push("x0_bypass", SEL_RS1, 0);
    step();
    wb(1'b0, '0, '0);
    exp_push("x0_after", SEL_RS1, 0);
    exp_push("x0_err", SEL_ERR, 0);
    step();

    // Scoreboard x5 and x10 so their write-backs are legitimate.
    issue(1'b1, 5'd5);  step();
    issue(1'b1, 5'd10); step();
    issue(1'b0, '0);

    wb(1'b1, 5'd5, 64'h1234); rs1_addr = 5'd5;
    exp_push("x5_bypass", SEL_RS1, 64'h1234);
    step();
    wb(1'b0, '0, '0);
    exp_push("x5_stored", SEL_RS1, 64'h1234);
    exp_push("a0_before", SEL_A0, 0);
    step();
    wb(1'b1, 5'd10, 64'h1);
    exp_push("a0_bypass", SEL_A0, 1);
    step();
    wb(1'b0, '0, '0);
    exp_push("a0_stored", SEL_A0, 1);
    exp_push("wb_err", SEL_ERR, 0);
    step();

    // Single pending write to x7.
    issue(1'b1, 5'd7); step();
    issue(1'b0, '0); rs2_addr = 5'd7; rs2_used = 1'b1;
    exp_push("x7_stall_c1", SEL_STALL, 1);
    step();
    exp_push("x7_stall_c2", SEL_STALL, 1);
    step();
    wb(1'b1, 5'd7, 64'h55);
    exp_push("x7_wb_stall", SEL_STALL, 0);
    exp_push("x7_wb_data", SEL_RS2, 64'h55);
    step();
    wb(1'b0, '0, '0);
    exp_push("x7_after_stall", SEL_STALL, 0);
    exp_push("x7_after_data", SEL_RS2, 64'h55);
    step();
    rs2_used = 1'b0;

    // Two pending writes to x3.
    issue(1'b1, 5'd3); step();
    issue(1'b1, 5'd3); step();
    issue(1'b0, '0); rs1_addr = 5'd3; rs1_used = 1'b1;
    exp_push("x3_cnt2_stall", SEL_STALL, 1);
    step();
    wb(1'b1, 5'd3, 64'hA);
    exp_push("x3_wb1_stall", SEL_STALL, 1);
    step();
    wb(1'b0, '0, '0);
    exp_push("x3_cnt1_stall", SEL_STALL, 1);
    step();
    wb(1'b1, 5'd3, 64'hB);
    exp_push("x3_wb2_stall", SEL_STALL, 0);
    exp_push("x3_wb2_data", SEL_RS1, 64'hB);
    step();
    wb(1'b0, '0, '0); issue(1'b1, 5'd3);
    exp_push("x3_cnt0_stall", SEL_STALL, 0);
    step();
    // cnt=1 with issue and write-back together: counter holds at 1.
    wb(1'b1, 5'd3, 64'hC);
    exp_push("x3_incdec_stall", SEL_STALL, 0);
    exp_push("x3_incdec_data", SEL_RS1, 64'hC);
    step();
    wb(1'b0, '0, '0); issue(1'b0, '0);
    exp_push("x3_held_stall", SEL_STALL, 1);
    step();
    wb(1'b1, 5'd3, 64'hD);
    exp_push("x3_drain_stall", SEL_STALL, 0);
    exp_push("x3_drain_data", SEL_RS1, 64'hD);
    step();
    wb(1'b0, '0, '0);
    exp_push("x3_idle_stall", SEL_STALL, 0);
    exp_push("x3_err", SEL_ERR, 0);
    step();

    // Saturate x4 counter: the fourth issue overflows.
    rs1_addr = 5'd4;
    issue(1'b1, 5'd4); step();
    issue(1'b1, 5'd4); step();
    issue(1'b1, 5'd4); step();
    exp_push("x4_cnt3_stall", SEL_STALL, 1);
    exp_push("x4_cnt3_err", SEL_ERR, 0);
    step();
    issue(1'b0, '0);
    exp_push("x4_ovf_err", SEL_ERR, 1);
    exp_push("x4_ovf_stall", SEL_STALL, 1);
    step();
    flush = 1'b1;
    exp_push("flush_cycle_stall", SEL_STALL, 1);
    exp_push("flush_cycle_err", SEL_ERR, 1);
    step();
    flush = 1'b0;
    exp_push("flush_after_stall", SEL_STALL, 0);
    exp_push("flush_keeps_err", SEL_ERR, 1);
    step();
    rs1_used = 1'b0;

    // Reset clears the error and the storage.
    rst = 1'b1; step();
    rst = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd7;
    exp_push("rst2_err", SEL_ERR, 0);
    exp_push("rst2_x5", SEL_RS1, 0);
    exp_push("rst2_x7", SEL_RS2, 0);
    exp_push("rst2_a0", SEL_A0, 0);
    step();

    // Flush overrides a same-cycle issue; the stale write-back then underflows.
    issue(1'b1, 5'd9); step();
    flush = 1'b1; rs1_addr = 5'd9; rs1_used = 1'b1;
    exp_push("x9_pre_flush_stall", SEL_STALL, 1);
    step();
    flush = 1'b0; issue(1'b0, '0);
    exp_push("x9_post_flush_stall", SEL_STALL, 0);
    exp_push("x9_post_flush_err", SEL_ERR, 0);
    step();
    wb(1'b1, 5'd9, 64'h99);
    exp_push("x9_wb_data", SEL_RS1, 64'h99);
    exp_push("x9_wb_err_now", SEL_ERR, 0);
    exp_push("x9_wb_stall", SEL_STALL, 0);
    step();
    wb(1'b0, '0, '0);
    exp_push("x9_unf_err", SEL_ERR, 1);
    exp_push("x9_stored", SEL_RS1, 64'h99);
    step();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Integer register file plus per-register pending-write scoreboard.
- Sink of the write-back stage's result/rd/we triple.
- Source of decode-stage operands, decode stall, and the a0 LSB consumed by the write-back ecall check.
- Writes commit at the clock edge. Reads are combinational with same-cycle write-back bypass, so a value written back this cycle is visible to decode this cycle.

Parameters:
- DATA_WIDTH, 64, register width in bits.
- REG_ADDR_W, 5, register address width; register count = 2**REG_ADDR_W.
- CNT_W, 2, width of each per-register in-flight write counter (max 2**CNT_W-1 outstanding writes).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_wb_we  input  1  write-back write enable.
- i_wb_addr  input  REG_ADDR_W  write-back destination register.
- i_wb_data  input  DATA_WIDTH  write-back result.
- i_rs1_addr  input  REG_ADDR_W  decode source 1 address.
- i_rs2_addr  input  REG_ADDR_W  decode source 2 address.
- i_rs1_used  input  1  instruction in decode reads rs1.
- i_rs2_used  input  1  instruction in decode reads rs2.
- o_rs1_data  output  DATA_WIDTH  source 1 operand, bypassed.
- o_rs2_data  output  DATA_WIDTH  source 2 operand, bypassed.
- i_issue_valid  input  1  decode instruction leaves decode this cycle (not stalled, not killed).
- i_issue_rd  input  REG_ADDR_W  destination of issuing instruction.
- i_issue_we  input  1  issuing instruction writes rd.
- i_flush  input  1  pipeline flush; discards all pending-write bookkeeping.
- o_stall  output  1  decode must hold: a used source has an outstanding write not satisfied by bypass.
- o_a0_lsb  output  1  bit 0 of x10, bypassed.
- o_sb_err  output  1  sticky scoreboard error (counter overflow/underflow).

Behaviour:
- Reset (i_rst high at edge):
  - all registers become 0.
  - all counters become 0.
  - o_sb_err becomes 0.
  - Reset takes priority over every same-cycle write, issue and flush.
- x0:
  - writes to x0 are discarded.
  - reads of x0 return 0.
  - issues to x0 never increment a counter.
  - x0 is never busy.
- Write: when i_wb_we and i_wb_addr!=0, regs[i_wb_addr] <= i_wb_data at the edge.
- Read, combinational, per port:
  - addr==0 -> 0.
  - else if i_wb_we and i_wb_addr==addr -> i_wb_data.
  - else regs[addr].
  - o_a0_lsb uses the same rule with addr=10, taking bit 0.
- Counters cnt[r]:
  - inc = i_issue_valid & i_issue_we & i_issue_rd==r & r!=0.
  - dec = i_wb_we & i_wb_addr==r & r!=0.
  - inc&dec -> unchanged.
  - inc only -> +1. If cnt was already max: hold at max and set o_sb_err.
  - dec only -> -1. If cnt was 0: stay 0 and set o_sb_err (unscoreboarded write-back; data still written).
- Busy per register r: cnt[r]>1, or (cnt[r]==1 and not dec[r]). In other words, the final pending write arriving this cycle is covered by bypass.
- o_stall = (i_rs1_used & busy[rs1]) | (i_rs2_used & busy[rs2]). Purely combinational, no latency.
- Flush:
  - all counters become 0 at the edge; overrides same-cycle inc/dec.
  - register writes in the same cycle still commit.
  - o_sb_err is not cleared by flush.
  - Write-backs of already-committed instructions that arrive after the flush decrement from 0 and set o_sb_err. Therefore flush must only be asserted once older writes have drained or are squashed (i_wb_we low).
- o_sb_err: sticky until reset.
- Latency: write visible on reads the same cycle (bypass) and from register storage thereafter. Counter update visible one cycle after the edge.

Decomposition:
- Shared package holds:
  - REG_ZERO=0 and REG_A0=10 address constants.
  - the cnt_t typedef (logic [CNT_W-1:0]).
  - the CNT_MAX constant.
- Natural sub-module: reg_scoreboard, which owns the counters, busy vector, o_stall and o_sb_err.
- Top owns storage, read/bypass muxing and o_a0_lsb.

Test Plan:
- Reset, then read x1..x31 -> all 0. Stall low. o_sb_err 0. Write x0=0xDEAD then read x0 -> 0.
- Write-back x5=0x1234 with rs1=5 in the same cycle -> o_rs1_data=0x1234 that cycle and the next. Set i_wb_addr=10, data LSB=1 -> o_a0_lsb=1 same cycle.
- Issue rd=7, we=1. Next cycle rs2=7, used -> o_stall=1 for two cycles. Third cycle write-back x7=0x55 -> o_stall=0, o_rs2_data=0x55 that cycle.
- Issue rd=3 twice (cnt=2), then a single write-back x3 -> stall stays 1. Second write-back -> stall 0. Same-cycle issue rd=3 with write-back x3 at cnt=1 -> cnt stays 1, stall 1.
- Issue rd=4 four times (CNT_W=2) -> cnt saturates at 3 and o_sb_err=1. Error persists through flush; cleared only by i_rst.
- Issue rd=9, then flush with a simultaneous issue rd=9 -> next cycle cnt[9]=0, stall 0. A later write-back x9 writes data and sets o_sb_err=1.
